// File: rtl/br_ctrl_pkg.sv
// Shared B-channel response encodings and the response severity helper.
package br_ctrl_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  // The encodings already rank by severity, so the larger code wins.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/br_master_port_arb.sv
// 2:1 round-robin B-response arbiter and mux for one master port.
//
// state    | meaning
// ARB_IDLE | nothing shown yet; grant follows requests and the priority pointer
// ARB_LOCK | lock_sel was shown without ready; grant frozen until its handshake
module br_master_port_arb (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic [1:0] resp_s0,
  input  logic [1:0] resp_s1,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] resp,
  output logic [1:0] gnt,
  output logic       hs
);

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  arb_state_e state, state_nxt;
  logic       ptr, ptr_nxt;
  logic       lock_sel, lock_sel_nxt;
  logic       sel;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= ARB_IDLE;
      ptr      <= 1'b0;
      lock_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_sel_nxt = lock_sel;
    sel          = 1'b0;
    valid        = 1'b0;

    if (state == ARB_LOCK) begin
      sel   = lock_sel;
      valid = req[lock_sel];
    end else begin
      sel   = (req == 2'b11) ? ptr : req[1];
      valid = |req;
    end

    resp = sel ? resp_s1 : resp_s0;
    gnt  = valid ? (sel ? 2'b10 : 2'b01) : 2'b00;
    hs   = valid & ready;

    if (hs) begin
      state_nxt = ARB_IDLE;
      ptr_nxt   = ~sel;
    end else if (valid) begin
      state_nxt    = ARB_LOCK;
      lock_sel_nxt = sel;
    end else begin
      state_nxt = ARB_IDLE;
    end
  end

endmodule

// File: rtl/br_channel_controller_top.sv
// B-channel crossbar for the 2x2 AXI4 interconnect: BID routing, per-master arbitration
// and, when BR_SPLIT_MERGE_EN is defined, merging of split-write responses.
module br_channel_controller_top
  import br_ctrl_pkg::*;
#(
  parameter int                         Num_Of_Masters  = 2,
  parameter int                         Num_Of_Slaves   = 2,
  parameter int                         Master_ID_Width = $clog2(Num_Of_Masters),
  parameter int                         AXI4_Aw_len     = 8,
  parameter logic [Master_ID_Width-1:0] M1_ID           = Master_ID_Width'(0),
  parameter logic [Master_ID_Width-1:0] M2_ID           = Master_ID_Width'(1)
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [1:0]                 Write_Data_Master,
  input  logic                       Write_Data_Finsh,
  input  logic [3:0]                 Rem,
  input  logic [3:0]                 Num_Of_Compl_Bursts,
  input  logic                       Is_Master_Part_Of_Split,
  input  logic                       Load_The_Original_Signals,
  output logic [1:0]                 S00_AXI_bresp,
  output logic                       S00_AXI_bvalid,
  input  logic                       S00_AXI_bready,
  output logic [1:0]                 S01_AXI_bresp,
  output logic                       S01_AXI_bvalid,
  input  logic                       S01_AXI_bready,
  input  logic [Master_ID_Width-1:0] M00_AXI_BID,
  input  logic [1:0]                 M00_AXI_bresp,
  input  logic                       M00_AXI_bvalid,
  output logic                       M00_AXI_bready,
  input  logic [Master_ID_Width-1:0] M01_AXI_BID,
  input  logic [1:0]                 M01_AXI_bresp,
  input  logic                       M01_AXI_bvalid,
  output logic                       M01_AXI_bready
);

  logic [Num_Of_Slaves-1:0]   s_valid, s_drop, s_tgt, s_bready;
  logic [1:0]                 s_resp [Num_Of_Slaves];
  logic [Master_ID_Width-1:0] s_bid  [Num_Of_Slaves];

  logic [Num_Of_Masters-1:0]  m_ready, arb_valid, arb_hs, arb_rdy, absorb;
  logic [1:0]                 arb_resp [Num_Of_Masters];
  logic [1:0]                 arb_gnt  [Num_Of_Masters];
  logic [1:0]                 m_resp   [Num_Of_Masters];

  assign s_valid   = {M01_AXI_bvalid, M00_AXI_bvalid};
  assign s_resp[0] = M00_AXI_bresp;
  assign s_resp[1] = M01_AXI_bresp;
  assign s_bid[0]  = M00_AXI_BID;
  assign s_bid[1]  = M01_AXI_BID;
  assign m_ready   = {S01_AXI_bready, S00_AXI_bready};

  for (genvar s = 0; s < Num_Of_Slaves; s++) begin : g_decode
    assign s_tgt[s]  = (s_bid[s] == M2_ID);
    assign s_drop[s] = (s_bid[s] != M1_ID) && (s_bid[s] != M2_ID);
  end

  for (genvar m = 0; m < Num_Of_Masters; m++) begin : g_port
    logic [1:0] req;
    assign req[0]     = s_valid[0] & ~s_drop[0] & (s_tgt[0] == 1'(m));
    assign req[1]     = s_valid[1] & ~s_drop[1] & (s_tgt[1] == 1'(m));
    // Absorbed intermediate split responses are accepted without the master's ready.
    assign arb_rdy[m] = absorb[m] | m_ready[m];

    br_master_port_arb u_arb (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .req     (req),
      .resp_s0 (s_resp[0]),
      .resp_s1 (s_resp[1]),
      .ready   (arb_rdy[m]),
      .valid   (arb_valid[m]),
      .resp    (arb_resp[m]),
      .gnt     (arb_gnt[m]),
      .hs      (arb_hs[m])
    );
  end

  for (genvar s = 0; s < Num_Of_Slaves; s++) begin : g_bready
    assign s_bready[s] = ARESETN & (s_drop[s] |
                                    (arb_gnt[0][s] & arb_rdy[0]) |
                                    (arb_gnt[1][s] & arb_rdy[1]));
  end

`ifdef BR_SPLIT_MERGE_EN
  logic [Num_Of_Masters-1:0]  ctx_armed;
  logic [AXI4_Aw_len-1:0]     ctx_total [Num_Of_Masters];
  logic [AXI4_Aw_len-1:0]     ctx_count [Num_Of_Masters];
  logic [1:0]                 ctx_acc   [Num_Of_Masters];
  logic [AXI4_Aw_len-1:0]     arm_total;
  logic [Master_ID_Width-1:0] arm_idx;
  logic                       unused_wdm_hi;

  assign arm_total     = AXI4_Aw_len'(Num_Of_Compl_Bursts) + AXI4_Aw_len'(Rem != 4'd0);
  assign arm_idx       = Write_Data_Master[Master_ID_Width-1:0];
  assign unused_wdm_hi = ^Write_Data_Master[1:Master_ID_Width];

  // Clear beats arming; arming beats a response update in the same cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int m = 0; m < Num_Of_Masters; m++) begin
        ctx_armed[m] <= 1'b0;
        ctx_total[m] <= '0;
        ctx_count[m] <= '0;
        ctx_acc[m]   <= RESP_OKAY;
      end
    end else begin
      for (int m = 0; m < Num_Of_Masters; m++) begin
        if (Load_The_Original_Signals) begin
          ctx_armed[m] <= 1'b0;
        end else if (Write_Data_Finsh && Is_Master_Part_Of_Split &&
                     arm_idx == Master_ID_Width'(m) && arm_total >= AXI4_Aw_len'(2)) begin
          ctx_armed[m] <= 1'b1;
          ctx_total[m] <= arm_total;
          ctx_count[m] <= '0;
          ctx_acc[m]   <= RESP_OKAY;
        end else if (ctx_armed[m] && arb_hs[m]) begin
          if (absorb[m]) begin
            ctx_acc[m]   <= resp_max(ctx_acc[m], arb_resp[m]);
            ctx_count[m] <= ctx_count[m] + AXI4_Aw_len'(1);
          end else begin
            ctx_armed[m] <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar m = 0; m < Num_Of_Masters; m++) begin : g_ctx
    logic final_rsp;
    assign absorb[m] = ctx_armed[m] && (ctx_count[m] < ctx_total[m] - AXI4_Aw_len'(1));
    assign final_rsp = ctx_armed[m] && !absorb[m];
    assign m_resp[m] = final_rsp ? resp_max(ctx_acc[m], arb_resp[m]) : arb_resp[m];
  end
`else
  logic unused_split_inputs;

  assign unused_split_inputs = ^{Write_Data_Master, Write_Data_Finsh, Rem, Num_Of_Compl_Bursts,
                                 Is_Master_Part_Of_Split, Load_The_Original_Signals, arb_hs};
  assign absorb = '0;

  for (genvar m = 0; m < Num_Of_Masters; m++) begin : g_pass
    assign m_resp[m] = arb_resp[m];
  end
`endif

  // Outputs are gated by reset so an in-flight transfer disappears at once.
  assign S00_AXI_bvalid = ARESETN & arb_valid[0] & ~absorb[0];
  assign S01_AXI_bvalid = ARESETN & arb_valid[1] & ~absorb[1];
  assign S00_AXI_bresp  = ARESETN ? m_resp[0] : 2'b00;
  assign S01_AXI_bresp  = ARESETN ? m_resp[1] : 2'b00;
  assign M00_AXI_bready = s_bready[0];
  assign M01_AXI_bready = s_bready[1];

endmodule

// File: tb/tb_br_channel_controller_top.sv
// Directed and randomized checks of the B-channel crossbar against a cycle-level behavioural model.
module tb_br_channel_controller_top;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [1:0] Write_Data_Master;
  logic       Write_Data_Finsh;
  logic [3:0] Rem;
  logic [3:0] Num_Of_Compl_Bursts;
  logic       Is_Master_Part_Of_Split;
  logic       Load_The_Original_Signals;
  logic [1:0] S00_AXI_bresp, S01_AXI_bresp;
  logic       S00_AXI_bvalid, S01_AXI_bvalid;
  logic       S00_AXI_bready, S01_AXI_bready;
  logic       M00_AXI_BID, M01_AXI_BID;
  logic [1:0] M00_AXI_bresp, M01_AXI_bresp;
  logic       M00_AXI_bvalid, M01_AXI_bvalid;
  logic       M00_AXI_bready, M01_AXI_bready;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic       sv      [2];
  logic       sbid    [2];
  logic [1:0] sresp   [2];
  logic       mrdy    [2];
  logic       keep    [2];
  logic       exp_rdy [2];
  int         prio    [2];
  int         shown   [2];
  int         win     [2];

  br_channel_controller_top dut (
    .ACLK                      (ACLK),
    .ARESETN                   (ARESETN),
    .Write_Data_Master         (Write_Data_Master),
    .Write_Data_Finsh          (Write_Data_Finsh),
    .Rem                       (Rem),
    .Num_Of_Compl_Bursts       (Num_Of_Compl_Bursts),
    .Is_Master_Part_Of_Split   (Is_Master_Part_Of_Split),
    .Load_The_Original_Signals (Load_The_Original_Signals),
    .S00_AXI_bresp             (S00_AXI_bresp),
    .S00_AXI_bvalid            (S00_AXI_bvalid),
    .S00_AXI_bready            (S00_AXI_bready),
    .S01_AXI_bresp             (S01_AXI_bresp),
    .S01_AXI_bvalid            (S01_AXI_bvalid),
    .S01_AXI_bready            (S01_AXI_bready),
    .M00_AXI_BID               (M00_AXI_BID),
    .M00_AXI_bresp             (M00_AXI_bresp),
    .M00_AXI_bvalid            (M00_AXI_bvalid),
    .M00_AXI_bready            (M00_AXI_bready),
    .M01_AXI_BID               (M01_AXI_BID),
    .M01_AXI_bresp             (M01_AXI_bresp),
    .M01_AXI_bvalid            (M01_AXI_bvalid),
    .M01_AXI_bready            (M01_AXI_bready)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_slaves(input logic v0, input logic b0, input logic [1:0] r0,
                              input logic v1, input logic b1, input logic [1:0] r1,
                              input logic rd0, input logic rd1);
    M00_AXI_bvalid = v0;  M00_AXI_BID = b0;  M00_AXI_bresp = r0;
    M01_AXI_bvalid = v1;  M01_AXI_BID = b1;  M01_AXI_bresp = r1;
    S00_AXI_bready = rd0; S01_AXI_bready = rd1;
  endtask

  task automatic clear_split();
    Write_Data_Master         = 2'd0;
    Write_Data_Finsh          = 1'b0;
    Rem                       = 4'd0;
    Num_Of_Compl_Bursts       = 4'd0;
    Is_Master_Part_Of_Split   = 1'b0;
    Load_The_Original_Signals = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    drive_slaves(0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
    clear_split();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state with live slave traffic present
    ARESETN = 1'b0;
    clear_split();
    drive_slaves(1, 0, 2'b10, 1, 1, 2'b11, 1, 1);
    #3;
    check_eq("rst_s00_valid", S00_AXI_bvalid, 1'b0);
    check_eq("rst_s01_valid", S01_AXI_bvalid, 1'b0);
    check_eq("rst_s00_resp",  S00_AXI_bresp,  2'b00);
    check_eq("rst_s01_resp",  S01_AXI_bresp,  2'b00);
    check_eq("rst_m00_ready", M00_AXI_bready, 1'b0);
    check_eq("rst_m01_ready", M01_AXI_bready, 1'b0);
    do_reset();

    // Slave 0 -> master 0
    drive_slaves(1, 0, 2'b00, 0, 0, 2'b00, 1, 0);
    #1;
    check_eq("t1_s00_valid", S00_AXI_bvalid, 1'b1);
    check_eq("t1_s00_resp",  S00_AXI_bresp,  2'b00);
    check_eq("t1_m00_ready", M00_AXI_bready, 1'b1);
    check_eq("t1_s01_valid", S01_AXI_bvalid, 1'b0);
    next_cycle();
    drive_slaves(0, 0, 2'b00, 0, 0, 2'b00, 0, 0);

    // Slave 1 -> master 1
    drive_slaves(0, 0, 2'b00, 1, 1, 2'b01, 0, 1);
    #1;
    check_eq("t2_s01_valid", S01_AXI_bvalid, 1'b1);
    check_eq("t2_s01_resp",  S01_AXI_bresp,  2'b01);
    check_eq("t2_m01_ready", M01_AXI_bready, 1'b1);
    check_eq("t2_s00_valid", S00_AXI_bvalid, 1'b0);
    next_cycle();
    drive_slaves(0, 0, 2'b00, 0, 0, 2'b00, 0, 0);

    // Crossed routing proceeds concurrently
    drive_slaves(1, 1, 2'b10, 1, 0, 2'b11, 1, 1);
    #1;
    check_eq("cc_s00_resp",  S00_AXI_bresp,  2'b11);
    check_eq("cc_s01_resp",  S01_AXI_bresp,  2'b10);
    check_eq("cc_m00_ready", M00_AXI_bready, 1'b1);
    check_eq("cc_m01_ready", M01_AXI_bready, 1'b1);
    next_cycle();

    // Both slaves to master 0 from reset priority
    do_reset();
    drive_slaves(1, 0, 2'b00, 1, 0, 2'b10, 1, 0);
    #1;
    check_eq("t3_first_valid", S00_AXI_bvalid, 1'b1);
    check_eq("t3_first_resp",  S00_AXI_bresp,  2'b00);
    check_eq("t3_m00_ready",   M00_AXI_bready, 1'b1);
    check_eq("t3_m01_stall",   M01_AXI_bready, 1'b0);
    next_cycle();
    drive_slaves(0, 0, 2'b00, 1, 0, 2'b10, 1, 0);
    #1;
    check_eq("t3_second_resp", S00_AXI_bresp,  2'b10);
    check_eq("t3_m01_ready",   M01_AXI_bready, 1'b1);
    check_eq("t3_m00_idle",    M00_AXI_bready, 1'b0);
    next_cycle();

    // Grant lock: slave 0 shown without ready while the pointer favours slave 1
    drive_slaves(1, 0, 2'b00, 0, 0, 2'b00, 1, 0);
    next_cycle();
    drive_slaves(1, 0, 2'b11, 0, 0, 2'b00, 0, 0);
    #1;
    check_eq("t4_valid",     S00_AXI_bvalid, 1'b1);
    check_eq("t4_resp",      S00_AXI_bresp,  2'b11);
    check_eq("t4_m00_wait",  M00_AXI_bready, 1'b0);
    next_cycle();
    drive_slaves(1, 0, 2'b11, 1, 0, 2'b01, 0, 0);
    #1;
    check_eq("t4_hold_resp", S00_AXI_bresp,  2'b11);
    check_eq("t4_hold_m00",  M00_AXI_bready, 1'b0);
    check_eq("t4_hold_m01",  M01_AXI_bready, 1'b0);
    next_cycle();
    drive_slaves(1, 0, 2'b11, 1, 0, 2'b01, 1, 0);
    #1;
    check_eq("t4_rel_resp",  S00_AXI_bresp,  2'b11);
    check_eq("t4_rel_m00",   M00_AXI_bready, 1'b1);
    check_eq("t4_rel_m01",   M01_AXI_bready, 1'b0);
    next_cycle();
    drive_slaves(0, 0, 2'b00, 1, 0, 2'b01, 1, 0);
    #1;
    check_eq("t4_next_resp", S00_AXI_bresp,  2'b01);
    check_eq("t4_next_m01",  M01_AXI_bready, 1'b1);
    next_cycle();

    // Reset asserted mid-handshake
    drive_slaves(1, 0, 2'b01, 1, 1, 2'b10, 1, 1);
    #1;
    check_eq("mr_pre_valid", S00_AXI_bvalid, 1'b1);
    #2;
    ARESETN = 1'b0;
    #1;
    check_eq("mr_s00_valid", S00_AXI_bvalid, 1'b0);
    check_eq("mr_s01_valid", S01_AXI_bvalid, 1'b0);
    check_eq("mr_m00_ready", M00_AXI_bready, 1'b0);
    check_eq("mr_m01_ready", M01_AXI_bready, 1'b0);
    do_reset();

`ifdef BR_SPLIT_MERGE_EN
    // Split of total 2 on master 0: first response absorbed, second carries the worst code
    Write_Data_Master = 2'd0; Write_Data_Finsh = 1'b1; Is_Master_Part_Of_Split = 1'b1;
    Num_Of_Compl_Bursts = 4'd1; Rem = 4'd3;
    next_cycle();
    clear_split();
    drive_slaves(1, 0, 2'b10, 0, 0, 2'b00, 0, 0);
    #1;
    check_eq("sp_absorb_valid", S00_AXI_bvalid, 1'b0);
    check_eq("sp_absorb_ready", M00_AXI_bready, 1'b1);
    next_cycle();
    drive_slaves(1, 0, 2'b00, 0, 0, 2'b00, 1, 0);
    #1;
    check_eq("sp_final_valid", S00_AXI_bvalid, 1'b1);
    check_eq("sp_final_resp",  S00_AXI_bresp,  2'b10);
    next_cycle();
    drive_slaves(1, 0, 2'b01, 0, 0, 2'b00, 1, 0);
    #1;
    check_eq("sp_after_resp", S00_AXI_bresp, 2'b01);
    next_cycle();
    drive_slaves(0, 0, 2'b00, 0, 0, 2'b00, 0, 0);

    // Clear coinciding with arming wins
    Write_Data_Master = 2'd0; Write_Data_Finsh = 1'b1; Is_Master_Part_Of_Split = 1'b1;
    Num_Of_Compl_Bursts = 4'd2; Load_The_Original_Signals = 1'b1;
    next_cycle();
    clear_split();
    drive_slaves(1, 0, 2'b10, 0, 0, 2'b00, 0, 0);
    #1;
    check_eq("sp_clear_valid", S00_AXI_bvalid, 1'b1);
    next_cycle();
    do_reset();
`endif

    // Randomized traffic against the behavioural model
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sbid[i] = 1'b0; sresp[i] = 2'b00; keep[i] = 1'b0;
      prio[i] = 0; shown[i] = -1;
    end
    repeat (1500) begin
      for (int s = 0; s < 2; s++) begin
        if (!keep[s]) begin
          sv[s]    = ($urandom_range(0, 9) < 6);
          sbid[s]  = 1'($urandom_range(0, 1));
          sresp[s] = 2'($urandom_range(0, 3));
        end
      end
      for (int m = 0; m < 2; m++) mrdy[m] = ($urandom_range(0, 9) < 7);
      drive_slaves(sv[0], sbid[0], sresp[0], sv[1], sbid[1], sresp[1], mrdy[0], mrdy[1]);
`ifdef BR_SPLIT_MERGE_EN
      Load_The_Original_Signals = 1'b1;
`else
      Load_The_Original_Signals = 1'($urandom_range(0, 1));
`endif
      Write_Data_Master       = 2'($urandom_range(0, 3));
      Write_Data_Finsh        = 1'($urandom_range(0, 1));
      Is_Master_Part_Of_Split = 1'($urandom_range(0, 1));
      Rem                     = 4'($urandom_range(0, 15));
      Num_Of_Compl_Bursts     = 4'($urandom_range(0, 15));
      #1;

      // A response shown last cycle without ready keeps the port; otherwise priority decides.
      for (int m = 0; m < 2; m++) begin
        if (shown[m] >= 0) win[m] = shown[m];
        else if (sv[0] && sbid[0] == 1'(m) && sv[1] && sbid[1] == 1'(m)) win[m] = prio[m];
        else if (sv[0] && sbid[0] == 1'(m)) win[m] = 0;
        else if (sv[1] && sbid[1] == 1'(m)) win[m] = 1;
        else win[m] = -1;
      end
      for (int s = 0; s < 2; s++)
        exp_rdy[s] = sv[s] && (win[sbid[s]] == s) && mrdy[sbid[s]];

      check_eq("rnd_s00_valid", S00_AXI_bvalid, (win[0] >= 0));
      check_eq("rnd_s01_valid", S01_AXI_bvalid, (win[1] >= 0));
      if (win[0] >= 0) check_eq("rnd_s00_resp", S00_AXI_bresp, sresp[win[0]]);
      if (win[1] >= 0) check_eq("rnd_s01_resp", S01_AXI_bresp, sresp[win[1]]);
      check_eq("rnd_m00_ready", M00_AXI_bready, exp_rdy[0]);
      check_eq("rnd_m01_ready", M01_AXI_bready, exp_rdy[1]);

      next_cycle();
      for (int m = 0; m < 2; m++) begin
        if (win[m] >= 0 && mrdy[m]) begin
          prio[m]  = 1 - win[m];
          shown[m] = -1;
        end else begin
          shown[m] = win[m];
        end
      end
      for (int s = 0; s < 2; s++) keep[s] = sv[s] && !exp_rdy[s];
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
